// File: rtl/vdc_pixel_shifter_pkg.sv
// Shared VDC definitions: attribute bit positions, column/render action codes
// and the blink phase selector.
package vdc_pixel_shifter_pkg;

  localparam int ATTR_ALT   = 7;
  localparam int ATTR_RVS   = 6;
  localparam int ATTR_UL    = 5;
  localparam int ATTR_BLINK = 4;

  typedef enum logic [1:0] {
    C_IDLE,
    C_BLANK,
    C_LOAD
  } cAction_t;

  typedef enum logic [1:0] {
    R_HOLD,
    R_REPEAT,
    R_ADVANCE
  } rAction_t;

  function automatic logic blink_phase(input logic [4:0] cnt, input logic rate);
    return rate ? cnt[4] : cnt[3];
  endfunction

endpackage

// File: rtl/vdc_pixel_shifter_if.sv
// Timing strobes, latch arrays, display registers and pixel output of the
// VDC pixel shifter.
interface vdc_pixel_shifter_if #(
  parameter int C_LATCH_WIDTH = 1,
  parameter int S_LATCH_WIDTH = 80
);
  logic       enable;
  logic       newCol;
  logic [7:0] col;
  logic [4:0] line;
  logic       newFrame;
  logic       dispWin;
  logic       rowbuf;
  logic [7:0] attrbuf [2][S_LATCH_WIDTH];
  logic [7:0] charbuf [C_LATCH_WIDTH];
  logic [3:0] reg_cth;
  logic [4:0] reg_ul;
  logic [3:0] reg_fg;
  logic [3:0] reg_bg;
  logic       reg_rvs;
  logic       reg_atr;
  logic       reg_text;
  logic       reg_dbl;
  logic       reg_cbrate;
  logic [3:0] rgbi;

  modport master (
    output enable, newCol, col, line, newFrame, dispWin, rowbuf, attrbuf, charbuf,
           reg_cth, reg_ul, reg_fg, reg_bg, reg_rvs, reg_atr, reg_text, reg_dbl,
           reg_cbrate,
    input  rgbi
  );

  modport slave (
    input  enable, newCol, col, line, newFrame, dispWin, rowbuf, attrbuf, charbuf,
           reg_cth, reg_ul, reg_fg, reg_bg, reg_rvs, reg_atr, reg_text, reg_dbl,
           reg_cbrate,
    output rgbi
  );
endinterface

// File: rtl/vdc_pixel_shifter.sv
// VDC pixel shifter: loads one glyph/bitmap byte per character column and
// serialises it into registered 4-bit RGBI pixels with attribute handling.
module vdc_pixel_shifter
  import vdc_pixel_shifter_pkg::*;
#(
  parameter int C_LATCH_WIDTH = 1,
  parameter int S_LATCH_WIDTH = 80
) (
  input  logic clk,
  input  logic reset,
  vdc_pixel_shifter_if.slave bus
);

  localparam int RI_W = (C_LATCH_WIDTH > 1) ? $clog2(C_LATCH_WIDTH) : 1;

  logic [7:0]      shifter_p0;
  logic [7:0]      attr_p0;
  logic [3:0]      px_p0;
  logic [3:0]      cth_p0;
  logic [RI_W-1:0] ri_p0;
  logic            cell_vis_p0;
  logic            dbl_ph_p0;
  logic [4:0]      blink_cnt;
  logic [3:0]      rgbi_p1;

  cAction_t        c_act;
  rAction_t        r_act;
  logic [7:0]      col_m1;
  logic [7:0]      attr_sel;
  logic [7:0]      char_sel;
  logic [RI_W-1:0] ri_next;
  logic [3:0]      pix;

  function automatic logic [3:0] pixel_colour(
    input logic [7:0] sh,
    input logic [7:0] at,
    input logic [3:0] p,
    input logic       vis,
    input logic       bitmap,
    input logic       atr_en,
    input logic       rvs,
    input logic       ul_hit,
    input logic       blink,
    input logic [3:0] fg_g,
    input logic [3:0] bg_g
  );
    logic [7:0] a;
    logic       b;
    logic [3:0] fg;
    logic [3:0] bg;
    a = atr_en ? at : 8'h00;
    b = (p < 4'd8) ? sh[7] : 1'b0;
    if (!bitmap) begin
      fg = atr_en ? at[3:0] : fg_g;
      bg = bg_g;
      b  = b | (a[ATTR_UL] & ul_hit);
      if (a[ATTR_BLINK] && blink) b = 1'b0;
      b  = b ^ a[ATTR_RVS];
    end else begin
      fg = atr_en ? at[7:4] : fg_g;
      bg = atr_en ? at[3:0] : bg_g;
    end
    b = b ^ rvs;
    return vis ? (b ? fg : bg) : 4'h0;
  endfunction

  // Column fetch: attribute and glyph selection for the next cell
  always_comb begin
    col_m1   = bus.col - 8'd1;
    attr_sel = 8'h00;
    for (int i = 0; i < S_LATCH_WIDTH; i++)
      if (col_m1 == 8'(i)) attr_sel = bus.attrbuf[bus.rowbuf][i];
    char_sel = 8'h00;
    for (int i = 0; i < C_LATCH_WIDTH; i++)
      if (ri_p0 == RI_W'(i)) char_sel = bus.charbuf[i];
  end

  assign ri_next = (ri_p0 == RI_W'(C_LATCH_WIDTH - 1)) ? '0 : ri_p0 + RI_W'(1);

  // A column load always wins over pixel stepping on the same enable
  always_comb begin
    c_act = C_IDLE;
    r_act = R_HOLD;
    if (bus.enable) begin
      if (bus.newCol)                    c_act = (bus.col == 8'd0) ? C_BLANK : C_LOAD;
      else if (bus.reg_dbl && !dbl_ph_p0) r_act = R_REPEAT;
      else                               r_act = R_ADVANCE;
    end
  end

  assign pix = pixel_colour(shifter_p0, attr_p0, px_p0, cell_vis_p0, bus.reg_text,
                            bus.reg_atr, bus.reg_rvs, (bus.line == bus.reg_ul),
                            blink_phase(blink_cnt, bus.reg_cbrate), bus.reg_fg, bus.reg_bg);

  // Stage p0: shifter/cell state; stage p1: registered pixel
  always_ff @(posedge clk) begin
    if (reset) begin
      shifter_p0  <= 8'h00;
      attr_p0     <= 8'h00;
      px_p0       <= 4'd0;
      cth_p0      <= 4'd0;
      ri_p0       <= '0;
      cell_vis_p0 <= 1'b0;
      dbl_ph_p0   <= 1'b0;
      blink_cnt   <= 5'd0;
      rgbi_p1     <= 4'h0;
    end else begin
      if (bus.enable) rgbi_p1 <= pix;
      if (bus.enable && bus.newFrame) blink_cnt <= blink_cnt + 5'd1;
      case (c_act)
        C_BLANK: begin
          shifter_p0 <= 8'h00;
          attr_p0    <= 8'h00;
          px_p0      <= 4'd0;
          cth_p0     <= bus.reg_cth;
          ri_p0      <= '0;
          dbl_ph_p0  <= 1'b0;
        end
        C_LOAD: begin
          shifter_p0  <= char_sel;
          attr_p0     <= attr_sel;
          px_p0       <= 4'd0;
          cth_p0      <= bus.reg_cth;
          ri_p0       <= ri_next;
          cell_vis_p0 <= bus.dispWin;
          dbl_ph_p0   <= 1'b0;
        end
        default: begin
          case (r_act)
            R_REPEAT: dbl_ph_p0 <= 1'b1;
            R_ADVANCE: begin
              dbl_ph_p0  <= 1'b0;
              shifter_p0 <= {shifter_p0[6:0], 1'b0};
              if (px_p0 < cth_p0) px_p0 <= px_p0 + 4'd1;
            end
            default: ;
          endcase
        end
      endcase
    end
  end

  assign bus.rgbi = rgbi_p1;

endmodule

// File: tb/tb_vdc_pixel_shifter.sv
// Scoreboard bench for vdc_pixel_shifter: a cell-level reference model feeds
// an expectation queue that a monitor drains on every reset or enable cycle.
module tb_vdc_pixel_shifter;

  localparam int CW = 2;
  localparam int SW = 80;

  logic clk = 1'b0;
  logic reset = 1'b0;

  vdc_pixel_shifter_if #(.C_LATCH_WIDTH(CW), .S_LATCH_WIDTH(SW)) bus();

  vdc_pixel_shifter #(.C_LATCH_WIDTH(CW), .S_LATCH_WIDTH(SW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  logic [3:0] exp_q[$];
  logic [3:0] cap[$];
  bit cap_en = 0;
  logic act;

  // Reference model: the cell currently on screen and enables since its load
  bit [7:0] m_glyph, m_attr;
  bit       m_vis;
  int       m_cth, m_k, m_ri, m_cnt;

  task automatic check(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic logic [3:0] ref_pixel();
    int n, p;
    bit b, blink;
    bit [7:0] a;
    logic [3:0] fg, bg;
    n = m_k / (bus.reg_dbl ? 2 : 1);
    p = (n < m_cth) ? n : m_cth;
    b = (p < 8 && n < 8) ? m_glyph[7-n] : 1'b0;
    blink = ((m_cnt / (bus.reg_cbrate ? 16 : 8)) % 2) == 1;
    a = bus.reg_atr ? m_attr : 8'h00;
    if (!bus.reg_text) begin
      fg = bus.reg_atr ? m_attr[3:0] : bus.reg_fg;
      bg = bus.reg_bg;
      if (a[5] && bus.line == bus.reg_ul) b = 1'b1;
      if (a[4] && blink) b = 1'b0;
      if (a[6]) b = !b;
    end else begin
      fg = bus.reg_atr ? m_attr[7:4] : bus.reg_fg;
      bg = bus.reg_atr ? m_attr[3:0] : bus.reg_bg;
    end
    if (bus.reg_rvs) b = !b;
    return m_vis ? (b ? fg : bg) : 4'h0;
  endfunction

  // Called just after a falling edge; applies one cycle and models it
  task automatic drive(input bit rst_i, input bit en, input bit nc, input logic [7:0] c,
                       input bit nf);
    int idx;
    reset = rst_i;
    bus.enable = en;
    bus.newCol = nc;
    bus.col = c;
    bus.newFrame = nf;
    if (rst_i) begin
      exp_q.push_back(4'h0);
      m_glyph = 0; m_attr = 0; m_vis = 0; m_cth = 0; m_k = 0; m_ri = 0; m_cnt = 0;
    end else if (en) begin
      exp_q.push_back(ref_pixel());
      if (nc) begin
        m_k = 0;
        m_cth = int'(bus.reg_cth);
        if (c == 8'd0) begin
          m_glyph = 0; m_attr = 0; m_ri = 0;
        end else begin
          m_glyph = bus.charbuf[m_ri];
          m_ri = (m_ri + 1) % CW;
          idx = int'(c) - 1;
          m_attr = (idx < SW) ? bus.attrbuf[bus.rowbuf][idx] : 8'h00;
          m_vis = bus.dispWin;
        end
      end else begin
        m_k++;
      end
      if (nf) m_cnt = (m_cnt + 1) % 32;
    end
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    act = reset || bus.enable;
    if (act) begin
      #1;
      if (exp_q.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        check("sb_rgbi", int'(bus.rgbi), int'(exp_q.pop_front()));
      end
      if (cap_en) cap.push_back(bus.rgbi);
    end
  end

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 8'd0, 0);
  endtask

  task automatic fill(input logic [7:0] a, input logic [7:0] ch);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < SW; i++) bus.attrbuf[r][i] = a;
    for (int i = 0; i < CW; i++) bus.charbuf[i] = ch;
  endtask

  task automatic set_defaults();
    bus.reg_text = 0; bus.reg_atr = 1; bus.reg_cth = 4'd7; bus.reg_dbl = 0;
    bus.reg_rvs = 0; bus.reg_ul = 5'd31; bus.line = 5'd0; bus.reg_fg = 4'hF;
    bus.reg_bg = 4'h0; bus.reg_cbrate = 0; bus.dispWin = 1; bus.rowbuf = 0;
  endtask

  // Columns 0..3, back-to-back enables, every output captured by enable index
  task automatic dir_row(input int len);
    cap.delete();
    cap_en = 1;
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < len; i++) drive(0, 1, i == 0, 8'(c), 0);
    cap_en = 0;
  endtask

  task automatic check_cap(input string name, input int idx, input int expected);
    if (cap.size() <= idx) check({name, "_missing"}, cap.size(), idx + 1);
    else check(name, int'(cap[idx]), expected);
  endtask

  task automatic rand_cell(input logic [7:0] c, input int full, input bit trunc);
    int len;
    len = (trunc && $urandom_range(0, 3) == 0) ? $urandom_range(1, full + 4) : full;
    for (int i = 0; i < CW; i++) bus.charbuf[i] = 8'($urandom);
    for (int i = 0; i < len; i++) begin
      while ($urandom_range(0, 3) == 0) drive(0, 0, 1'($urandom), c, 1'($urandom));
      if ($urandom_range(0, 299) == 0) drive(1, 0, 0, c, 0);
      drive(0, 1, i == 0, c, $urandom_range(0, 15) == 0);
    end
  endtask

  initial begin
    logic [7:0] pat;
    int full;
    bus.enable = 0; bus.newCol = 0; bus.col = 0; bus.newFrame = 0;
    set_defaults();
    fill(8'h00, 8'h00);
    @(negedge clk);

    // Reset state, then output stays blank with no column load
    do_reset(3);
    bus.reg_bg = 4'h5; bus.reg_rvs = 1;
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 8'd0, 0);
    set_defaults();

    // Text glyph with attribute colour
    fill(8'h03, 8'hA5);
    dir_row(8);
    pat = 8'hA5;
    for (int j = 0; j < 8; j++) check_cap("text_a5", 17 + j, pat[7-j] ? 3 : 0);

    // Wide cell: pixels beyond 8 are background
    bus.reg_cth = 4'd9; bus.reg_atr = 0; bus.reg_fg = 4'hF; bus.reg_bg = 4'h2;
    fill(8'h00, 8'hFF);
    dir_row(10);
    for (int j = 0; j < 10; j++) check_cap("cth9", 21 + j, j < 8 ? 15 : 2);

    // Bitmap mode, single then double width
    do_reset(1);
    set_defaults();
    bus.reg_text = 1;
    fill(8'h5A, 8'h80);
    dir_row(8);
    for (int j = 0; j < 8; j++) check_cap("bitmap", 17 + j, j == 0 ? 5 : 10);
    do_reset(1);
    bus.reg_dbl = 1;
    dir_row(16);
    for (int j = 0; j < 16; j++) check_cap("bitmap_dbl", 33 + j, j < 2 ? 5 : 10);

    // Blink on 16-frame rate
    do_reset(1);
    set_defaults();
    bus.reg_bg = 4'h6;
    fill(8'h10, 8'hA5);
    for (int i = 0; i < 8; i++) drive(0, 1, 0, 8'd0, 1);
    dir_row(8);
    for (int j = 0; j < 8; j++) check_cap("blink_on", 17 + j, 6);
    for (int i = 0; i < 8; i++) drive(0, 1, 0, 8'd0, 1);
    dir_row(8);
    pat = 8'hA5;
    for (int j = 0; j < 8; j++) check_cap("blink_off", 17 + j, pat[7-j] ? 0 : 6);

    // Reset in the middle of a column blanks the rest of it
    bus.reg_bg = 4'h9; bus.reg_rvs = 1;
    fill(8'h00, 8'hFF);
    drive(0, 1, 1, 8'd0, 0);
    drive(0, 1, 1, 8'd1, 0);
    drive(0, 1, 0, 8'd1, 0);
    drive(1, 1, 0, 8'd1, 0);
    cap.delete();
    cap_en = 1;
    for (int i = 0; i < 6; i++) drive(0, 1, 0, 8'd1, 0);
    cap_en = 0;
    for (int j = 0; j < 6; j++) check_cap("rst_mid", j, 0);

    // Cell outside the display window
    bus.reg_rvs = 0;
    bus.dispWin = 0;
    dir_row(8);
    for (int j = 0; j < 8; j++) check_cap("dispwin0", 17 + j, 0);

    // Randomized rows against the reference model
    for (int ph = 0; ph < 6; ph++) begin
      do_reset(2);
      bus.reg_dbl = 1'($urandom);
      bus.reg_cbrate = 1'($urandom);
      for (int r = 0; r < 2; r++)
        for (int i = 0; i < SW; i++) bus.attrbuf[r][i] = 8'($urandom);
      for (int row = 0; row < 2; row++) begin
        bus.rowbuf = 1'($urandom);
        for (int c = 0; c < 85; c++) begin
          if (c == 0 || $urandom_range(0, 7) == 0) begin
            bus.reg_text = 1'($urandom); bus.reg_atr = 1'($urandom);
            bus.reg_rvs = ($urandom_range(0, 3) == 0); bus.reg_fg = 4'($urandom);
            bus.reg_bg = 4'($urandom); bus.reg_cth = 4'($urandom_range(5, 11));
            bus.reg_ul = 5'($urandom); bus.line = $urandom_range(0, 1) ? bus.reg_ul : 5'($urandom);
            bus.dispWin = ($urandom_range(0, 5) != 0);
          end
          full = (int'(bus.reg_cth) + 1) * (bus.reg_dbl ? 2 : 1);
          rand_cell(8'(c), full, 1);
        end
      end
    end

    drive(0, 0, 0, 8'd0, 0);
    drive(0, 0, 0, 8'd0, 0);
    check("sb_leftover", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "timeout");
  end

endmodule
